money_fnd_scanner: RTL and testbench

- Downstream consumer of the main logic's `display_money_binary` value.
- Converts the binary money amount to decimal with a sequential shift-add-3 (double-dabble) engine.
- Appends fixed trailing zero digits for currency scaling and applies leading-zero blanking.
- Drives the 8-digit multiplexed FND array: one digit active at a time, refreshed round-robin.

---
 rtl/money_fnd_scanner.sv | 151 +++++++++++++++
 tb/tb_money_fnd_scanner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/money_fnd_scanner.sv
// Binary money amount to 8-digit multiplexed FND: sequential double-dabble conversion,
// fixed trailing scale zeros, leading-zero blanking and round-robin digit scanning.
module money_fnd_scanner #(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned SCALE_ZEROS = 2,
  parameter int unsigned SCAN_DIV    = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] display_money_binary,
  output logic [7:0]      seg_com,
  output logic [7:0]      seg_array,
  output logic            conv_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned BIT_W = $clog2(IN_W + 1);

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  in_q;
  logic [IN_W-1:0]  last_q, last_d;
  logic [IN_W-1:0]  sh_q, sh_d;
  logic [19:0]      work_q, work_d;
  logic [19:0]      shown_q, shown_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [18:0]      bcd_adj;

  logic [CNT_W-1:0] scan_q, scan_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       seg_com_q, seg_array_q;
  logic [31:0]      pos_vec;
  logic [31:0]      pos_high;
  logic [3:0]       digit_val;
  logic             digit_blank;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hFC;
      4'd1:    seg_code = 8'h60;
      4'd2:    seg_code = 8'hDA;
      4'd3:    seg_code = 8'hF2;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'hB6;
      4'd6:    seg_code = 8'hBE;
      4'd7:    seg_code = 8'hE0;
      4'd8:    seg_code = 8'hFE;
      4'd9:    seg_code = 8'hF6;
      default: seg_code = 8'h00;
    endcase
  endfunction

  // Add-3 correction; the top nibble never carries out, so only its low 3 bits survive the shift.
  always_comb begin
    bcd_adj = work_q[18:0];
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    if (work_q[19:16] >= 4'd5) bcd_adj[18:16] = 3'(work_q[19:16] + 4'd3);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    work_d  = work_q;
    shown_d = shown_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (in_q != last_q) state_d = LOAD;
      LOAD: begin
        sh_d    = in_q;
        last_d  = in_q;
        work_d  = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {work_d, sh_d} = {bcd_adj, sh_q, 1'b0};
        bit_d          = bit_q + 1'b1;
        if (bit_q == BIT_W'(IN_W - 1)) state_d = DONE;
      end
      DONE: begin
        shown_d = work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      last_q  <= '0;
      sh_q    <= '0;
      work_q  <= '0;
      shown_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= display_money_binary;
      last_q  <= last_d;
      sh_q    <= sh_d;
      work_q  <= work_d;
      shown_q <= shown_d;
      bit_q   <= bit_d;
    end
  end

  assign conv_busy = (state_q != IDLE);

  // Scale zeros sit below the BCD digits; everything above position 7 is simply ignored.
  always_comb begin
    pos_vec     = 32'(shown_q) << (4 * SCALE_ZEROS);
    pos_high    = pos_vec >> {digit_q, 2'b00};
    digit_val   = pos_vec[{digit_q, 2'b00} +: 4];
    digit_blank = (pos_high == 32'd0) && (digit_q != 3'd0);
  end

  always_comb begin
    scan_d  = scan_q + 1'b1;
    digit_d = digit_q;
    if (scan_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q      <= '0;
      digit_q     <= '0;
      seg_com_q   <= 8'hFF;
      seg_array_q <= 8'h00;
    end else begin
      scan_q      <= scan_d;
      digit_q     <= digit_d;
      seg_com_q   <= ~(8'b1 << digit_q);
      seg_array_q <= digit_blank ? 8'h00 : seg_code(digit_val);
    end
  end

  assign seg_com   = seg_com_q;
  assign seg_array = seg_array_q;

endmodule

// File: tb/tb_money_fnd_scanner.sv
// Self-checking bench for money_fnd_scanner: reference display computed from the decimal value
// of amount * 10^SCALE_ZEROS, compared against every scanned digit.
module tb_money_fnd_scanner;

  localparam int IN_W = 8;
  localparam int SZ   = 2;
  localparam int DIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] seg_com;
  logic [7:0] seg_array;
  logic       conv_busy;

  int errors = 0;
  int checks = 0;
  int last_v = 0;

  money_fnd_scanner #(
    .IN_W       (IN_W),
    .SCALE_ZEROS(SZ),
    .SCAN_DIV   (DIV)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .display_money_binary(din),
    .seg_com             (seg_com),
    .seg_array           (seg_array),
    .conv_busy           (conv_busy)
  );

  always #5 clk = ~clk;

  // Expected segment code for position p when the amount is v.
  function automatic logic [7:0] exp_seg(input int v, input int p);
    int disp;
    int pw;
    disp = v;
    for (int i = 0; i < SZ; i++) disp = disp * 10;
    pw = 1;
    for (int i = 0; i < p; i++) pw = pw * 10;
    if (p > 0 && disp < pw) return 8'h00;
    case ((disp / pw) % 10)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  // Position selected by an active-low one-hot digit select, -1 if not exactly one bit low.
  function automatic int pos_of(input logic [7:0] com);
    int n;
    int p;
    n = 0;
    p = -1;
    for (int i = 0; i < 8; i++) begin
      if (com[i] === 1'b0) begin
        n++;
        p = i;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  task automatic test_reset();
    logic [7:0] exp_com;
    int n;
    rst = 1'b0;
    din = 8'd57;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_com !== 8'hFF) begin
      errors++;
      $display("FAIL reset_com: got %h want ff", seg_com);
    end
    checks++;
    if (seg_array !== 8'h00) begin
      errors++;
      $display("FAIL reset_seg: got %h want 00", seg_array);
    end
    checks++;
    if (conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", conv_busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      exp_com = ~(8'b1 << (i / DIV));
      checks++;
      if (seg_com !== exp_com) begin
        errors++;
        $display("FAIL release_com: cycle %0d got %h want %h", i, seg_com, exp_com);
      end
      checks++;
      if (seg_array !== exp_seg(0, i / DIV)) begin
        errors++;
        $display("FAIL release_seg: cycle %0d got %h want %h", i, seg_array, exp_seg(0, i / DIV));
      end
    end
    n = 0;
    while (conv_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL release_conv_end: busy=%b still high after %0d cycles", conv_busy, n);
    end
    last_v = 57;
  endtask

  task automatic test_convert(input int v, input string tag);
    int n;
    int len;
    int pos;
    logic [7:0] seen;
    din = 8'(v);
    n = 0;
    while (!conv_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (conv_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_start: busy=%b after %0d cycles, want 1", tag, conv_busy, n);
    end
    len = 0;
    while (conv_busy && len < 100) begin
      @(negedge clk);
      len++;
    end
    checks++;
    if (len != IN_W + 2) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles want %0d", tag, len, IN_W + 2);
    end
    @(negedge clk);
    seen = 8'h00;
    for (int i = 0; i < 8 * DIV; i++) begin
      pos = pos_of(seg_com);
      checks++;
      if (pos < 0) begin
        errors++;
        $display("FAIL %s_onehot: seg_com=%h not one-hot-low", tag, seg_com);
      end else begin
        seen[pos] = 1'b1;
        checks++;
        if (seg_array !== exp_seg(v, pos)) begin
          errors++;
          $display("FAIL %s_seg: value %0d pos %0d got %h want %h", tag, v, pos, seg_array,
                   exp_seg(v, pos));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen !== 8'hFF) begin
      errors++;
      $display("FAIL %s_scan_cover: visited %h want ff", tag, seen);
    end
    last_v = v;
  endtask

  task automatic test_mid_change(input int prev);
    int n;
    int pos;
    int disp;
    int pulses;
    logic pb;
    int q[$];
    din = 8'd200;
    n = 0;
    while (!conv_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    din = 8'd9;
    q = '{200, 9};
    disp = prev;
    pulses = 1;
    pb = conv_busy;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      pos = pos_of(seg_com);
      checks++;
      if (pos < 0 || seg_array !== exp_seg(disp, pos)) begin
        errors++;
        $display("FAIL mid_change_seg: showing %0d pos %0d com %h got %h want %h", disp, pos,
                 seg_com, seg_array, (pos < 0) ? 8'h00 : exp_seg(disp, pos));
      end
      if (pb && !conv_busy && q.size() > 0) disp = q.pop_front();
      if (!pb && conv_busy) pulses++;
      pb = conv_busy;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL mid_change_pulses: got %0d busy pulses want 2", pulses);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL mid_change_done: %0d conversions never finished, want 0", q.size());
    end
    last_v = 9;
  endtask

  task automatic test_reset_mid();
    int n;
    din = 8'd100;
    n = 0;
    while (!conv_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (seg_com !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_com: got %h want ff", seg_com);
    end
    checks++;
    if (conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b want 0", conv_busy);
    end
    checks++;
    if (seg_array !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_seg: got %h want 00", seg_array);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_convert(100, "reset_mid");
  endtask

  task automatic test_random();
    int v;
    for (int k = 0; k < 5; k++) begin
      v = int'($urandom_range(0, 255));
      if (v == last_v) v = (v + 1) % 256;
      test_convert(v, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert(0, "zero_first");
    test_convert(57, "conv57");
    test_convert(0, "zero");
    test_convert(255, "max");
    test_mid_change(last_v);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
